resp_compactor: RTL and testbench



---
 rtl/resp_compactor.sv | 118 +++++++++++
 tb/tb_resp_compactor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/resp_compactor.sv
// Response compactor: skips warm-up samples of the CUT output, then folds them into a SISR.
// Define RESP_GOLDEN_CMP_EN to build the registered golden-signature compare driving PASS.
module resp_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED  = '0,
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] SKIP  = CNT_W'(3)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] LEN,
    input  logic             SIN,
    input  logic             SIN_VLD,
    input  logic [SIG_W-1:0] GOLDEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIG,
    output logic             PASS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [SIG_W-1:0] sig, sig_n;
    logic [CNT_W-1:0] skip_cnt, skip_n;
    logic [CNT_W-1:0] len_cnt, len_n;

    function automatic logic [SIG_W-1:0] sisr(input logic [SIG_W-1:0] s,
                                              input logic b);
        logic [SIG_W-1:0] r;
        r    = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0);
        r[0] = r[0] ^ b;
        return r;
    endfunction

    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= S_IDLE;
            sig      <= '0;
            skip_cnt <= '0;
            len_cnt  <= '0;
        end else begin
            state    <= state_n;
            sig      <= sig_n;
            skip_cnt <= skip_n;
            len_cnt  <= len_n;
        end
    end

    always_comb begin
        state_n = state;
        sig_n   = sig;
        skip_n  = skip_cnt;
        len_n   = len_cnt;
        unique case (state)
            S_IDLE, S_DONE: begin
                // the sample coincident with START is never consumed
                if (START) begin
                    sig_n  = SEED;
                    skip_n = SKIP;
                    len_n  = LEN;
                    if (LEN == '0)
                        state_n = S_DONE;
                    else if (SKIP == '0)
                        state_n = S_RUN;
                    else
                        state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (SIN_VLD) begin
                    skip_n = skip_cnt - 1'b1;
                    if (skip_cnt == CNT_W'(1))
                        state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (SIN_VLD) begin
                    sig_n = sisr(sig, SIN);
                    len_n = len_cnt - 1'b1;
                    if (len_cnt == CNT_W'(1))
                        state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign BUSY = (state == S_FLUSH) || (state == S_RUN);
    assign DONE = (state == S_DONE);
    assign SIG  = sig;

`ifdef RESP_GOLDEN_CMP_EN
    logic pass_q;

    // compare against next-state values so PASS is valid with the first DONE cycle
    always_ff @(posedge CK) begin
        if (RST)
            pass_q <= 1'b0;
        else
            pass_q <= (state_n == S_DONE) && (sig_n == GOLDEN);
    end

    assign PASS = pass_q;
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
    assign PASS          = 1'b0;
`endif

endmodule

// File: tb/tb_resp_compactor.sv
// Directed bench for resp_compactor: three instances (SKIP=3, SKIP=0, nonzero SEED)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_resp_compactor;

    logic        CK;
    logic        RST;
    logic        START;
    logic [7:0]  LEN;
    logic        SIN;
    logic        SIN_VLD;
    logic [15:0] GOLDEN;

    logic        b3, d3, p3;
    logic [15:0] s3;
    logic        b0, d0, p0;
    logic [15:0] s0;
    logic        bs, ds, ps;
    logic [15:0] ss;

    int n_chk;
    int n_fail;

`ifdef RESP_GOLDEN_CMP_EN
    localparam logic CMP = 1'b1;
`else
    localparam logic CMP = 1'b0;
`endif

    resp_compactor u3 (
        .CK(CK), .RST(RST), .START(START), .LEN(LEN),
        .SIN(SIN), .SIN_VLD(SIN_VLD), .GOLDEN(GOLDEN),
        .BUSY(b3), .DONE(d3), .SIG(s3), .PASS(p3)
    );

    resp_compactor #(.SKIP(8'd0)) u0 (
        .CK(CK), .RST(RST), .START(START), .LEN(LEN),
        .SIN(SIN), .SIN_VLD(SIN_VLD), .GOLDEN(GOLDEN),
        .BUSY(b0), .DONE(d0), .SIG(s0), .PASS(p0)
    );

    resp_compactor #(.SKIP(8'd0), .SEED(16'h1234)) us (
        .CK(CK), .RST(RST), .START(START), .LEN(LEN),
        .SIN(SIN), .SIN_VLD(SIN_VLD), .GOLDEN(GOLDEN),
        .BUSY(bs), .DONE(ds), .SIG(ss), .PASS(ps)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int         n;
        n_chk   = 0;
        n_fail  = 0;
        pat     = 8'b1011_0010;
        RST     = 1'b1;
        START   = 1'b1;
        LEN     = 8'd5;
        SIN     = 1'b1;
        SIN_VLD = 1'b1;
        GOLDEN  = 16'h0;

        // reset with START held
        tick();
        tick();
        chk("rst_sig", s3, 16'h0);
        chk("rst_busy", b3, 1'b0);
        chk("rst_done", d3, 1'b0);
        chk("rst_pass", p3, 1'b0);
        RST   = 1'b0;
        START = 1'b0;

        // warm-up discard: SKIP=3, LEN=1, SIN all ones
        LEN     = 8'd1;
        SIN     = 1'b1;
        SIN_VLD = 1'b1;
        START   = 1'b1;
        tick();
        START = 1'b0;
        chk("warm_busy", b3, 1'b1);
        chk("warm_sig_hold", s3, 16'h0);
        n = 0;
        while (!d3 && n < 20) begin
            tick();
            n++;
        end
        chk("warm_lat", n, 4);
        chk("warm_sig", s3, 16'h0001);
        chk("warm_excl", {b3, d3}, 2'b01);
        SIN = 1'b0;
        tick();
        tick();
        chk("done_frozen", s3, 16'h0001);
        chk("done_hold", d3, 1'b1);

        // polynomial wrap on SKIP=0 instance
        SIN_VLD = 1'b0;
        do_reset();
        GOLDEN = 16'hEFDE;
        LEN    = 8'd17;
        START  = 1'b1;
        tick();
        START   = 1'b0;
        SIN     = 1'b1;
        SIN_VLD = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("wrap_ffff", s0, 16'hFFFF);
        chk("wrap_busy", b0, 1'b1);
        tick();
        SIN_VLD = 1'b0;
        chk("wrap_done", d0, 1'b1);
        chk("wrap_sig", s0, 16'hEFDE);
        chk("wrap_pass", p0, CMP);
        GOLDEN = 16'hEFDF;
        tick();
        chk("wrap_nopass", p0, 1'b0);

        // stalls with ignored mid-gap START
        do_reset();
        LEN   = 8'd2;
        START = 1'b1;
        tick();
        START   = 1'b0;
        SIN     = 1'b1;
        SIN_VLD = 1'b1;
        tick();
        SIN_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            START = (i == 2);
            LEN   = (i == 2) ? 8'd0 : 8'd2;
            tick();
            chk("stall_busy", b0, 1'b1);
        end
        START   = 1'b0;
        SIN     = 1'b0;
        SIN_VLD = 1'b1;
        tick();
        SIN_VLD = 1'b0;
        chk("stall_done", d0, 1'b1);
        chk("stall_sig", s0, 16'h0002);

        // LEN=0 then restart from DONE on seeded instance
        do_reset();
        LEN   = 8'd0;
        START = 1'b1;
        tick();
        chk("len0_done", ds, 1'b1);
        chk("len0_busy", bs, 1'b0);
        chk("len0_seed", ss, 16'h1234);
        LEN     = 8'd1;
        SIN     = 1'b1;
        SIN_VLD = 1'b1;
        tick();
        START = 1'b0;
        chk("restart_drop", ds, 1'b0);
        chk("restart_reload", ss, 16'h1234);
        tick();
        SIN_VLD = 1'b0;
        chk("restart_done", ds, 1'b1);
        chk("restart_sig", ss, 16'h2469);

        // abort mid-RUN, then a fresh full run
        do_reset();
        LEN   = 8'd8;
        START = 1'b1;
        tick();
        START   = 1'b0;
        SIN_VLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SIN = pat[7-i];
            tick();
        end
        chk("abort_pre", s0, 16'h0016);
        SIN_VLD = 1'b0;
        RST     = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_sig", s0, 16'h0);
        chk("abort_flags", {b0, d0, p0}, 3'b000);
        START = 1'b1;
        tick();
        START   = 1'b0;
        SIN_VLD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            SIN = pat[7-i];
            tick();
        end
        SIN_VLD = 1'b0;
        chk("rerun_done", d0, 1'b1);
        chk("rerun_sig", s0, 16'h00B2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
